fpu_serial_frontend: RTL and testbench

Parametrised serial front end for the half-precision FPU tile: deserialises two operands arriving chunk-serially on narrow pins, issues them to an external FP core over a start/done handshake, buffers results in a FIFO and streams them out chunk-serially with valid/ready backpressure. It generalises the fixed 4-bit-in / 8-bit-out add/mul wrapper:
- adds subtract and pass-through modes;
- adds a parametrised result queue;
- adds frame-abort and frame-drop error flags.

---
 rtl/fpu_serial_pkg.sv | 35 +++
 rtl/fpu_serial_frontend_if.sv | 46 ++++
 rtl/fpu_result_serializer.sv | 96 +++++++++
 rtl/fpu_serial_frontend.sv | 139 +++++++++++++
 tb/tb_fpu_serial_frontend.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_serial_pkg
// Summary  : Shared types and default widths for the FPU serial front end.
// Revision : 1.0 - initial release
// ============================================================================
package fpu_serial_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_IN_W       = 4;
  localparam int DEF_OUT_W      = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4
  } state_e;

  // The core only knows mul and add; subtract rides on the adder.
  function automatic logic op_uses_add(op_e op);
    return (op != OP_MUL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_serial_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_serial_frontend_if
// Summary  : Operand, core-handshake and result-stream bundle of the front end.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_serial_frontend_if
  import fpu_serial_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W
);

  logic              in_en;
  logic [1:0]        op_sel;
  logic [IN_W-1:0]   in_a;
  logic [IN_W-1:0]   in_b;
  logic [DATA_W-1:0] core_a;
  logic [DATA_W-1:0] core_b;
  logic              core_op;
  logic              core_start;
  logic              core_done;
  logic [DATA_W-1:0] core_result;
  logic [OUT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              frame_err;
  logic              drop_err;

  modport master (
    output in_en, op_sel, in_a, in_b, core_done, core_result, out_ready,
    input  core_a, core_b, core_op, core_start, out_data, out_valid,
           out_last, busy, frame_err, drop_err
  );

  modport slave (
    input  in_en, op_sel, in_a, in_b, core_done, core_result, out_ready,
    output core_a, core_b, core_op, core_start, out_data, out_valid,
           out_last, busy, frame_err, drop_err
  );

endinterface
`default_nettype wire

// File: rtl/fpu_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_serializer
// Summary  : Result FIFO streaming the head entry out chunk by chunk, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_serializer
  import fpu_serial_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             i_push,
  input  logic [DATA_W-1:0]                i_push_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_count,
  output logic [OUT_W-1:0]                 o_out_data,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic                             o_out_last
);

  localparam int c_n_out   = DATA_W / OUT_W;
  localparam int c_chunk_w = (c_n_out > 1) ? $clog2(c_n_out) : 1;
  localparam int c_ptr_w   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_chunk_w-1:0] c_last_chunk = c_chunk_w'(c_n_out - 1);
  localparam logic [c_ptr_w-1:0]   c_last_ptr   = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [c_cnt_w-1:0]   c_depth      = c_cnt_w'(FIFO_DEPTH);

  logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_cnt_w-1:0]   r_count;
  logic [c_chunk_w-1:0] r_chunk;

  logic                 w_valid;
  logic                 w_last;
  logic                 w_fire;
  logic                 w_pop;
  logic                 w_wr;
  logic [DATA_W-1:0]    w_head;
  logic [OUT_W-1:0]     w_chunks [c_n_out];

  assign w_head  = r_mem[r_rd_ptr];
  assign w_valid = (r_count != '0);
  assign w_last  = w_valid && (r_chunk == c_last_chunk);
  assign w_fire  = w_valid && i_out_ready;
  assign w_pop   = w_fire && w_last;
  // A pop on the same edge frees the slot, so a push into a full FIFO is safe.
  assign w_wr    = i_push && ((r_count != c_depth) || w_pop);

  for (genvar gi = 0; gi < c_n_out; gi++) begin : g_chunk
    assign w_chunks[gi] = w_head[gi*OUT_W +: OUT_W];
  end

  always_ff @(posedge clock) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_chunk  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_fire) begin
        r_chunk <= w_last ? '0 : r_chunk + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_out_valid = w_valid;
  assign o_out_last  = w_last;
  assign o_out_data  = w_valid ? w_chunks[r_chunk] : '0;

endmodule
`default_nettype wire

// File: rtl/fpu_serial_frontend.sv
`default_nettype none
// ============================================================================
// Module   : fpu_serial_frontend
// Summary  : Deserialises operand frames, drives the FP core handshake, queues results.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_serial_frontend
  import fpu_serial_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  fpu_serial_frontend_if.slave  bus
);

  localparam int c_n_in  = DATA_W / IN_W;
  localparam int c_cnt_w = (c_n_in > 1) ? $clog2(c_n_in) : 1;
  localparam int c_fcnt_w = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_cnt_w-1:0]  c_last_in = c_cnt_w'(c_n_in - 1);
  localparam logic [c_fcnt_w-1:0] c_depth   = c_fcnt_w'(FIFO_DEPTH);

  localparam logic [2:0] c_st_idle  = 3'(IDLE);
  localparam logic [2:0] c_st_load  = 3'(LOAD);
  localparam logic [2:0] c_st_issue = 3'(ISSUE);
  localparam logic [2:0] c_st_wait  = 3'(WAIT);
  localparam logic [2:0] c_st_push  = 3'(PUSH);

  logic [2:0]          r_state;
  logic                r_prev_en;
  logic [c_cnt_w-1:0]  r_in_cnt;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  op_e                 r_op;
  logic                r_frame_err;
  logic                r_drop_err;

  logic [c_fcnt_w-1:0] w_fifo_count;
  logic                w_busy;
  logic                w_start_edge;
  logic                w_accept;
  logic                w_push;
  logic [DATA_W-1:0]   w_push_data;

  // Full FIFO counts as busy so every accepted frame already owns a slot.
  assign w_busy       = (r_state != c_st_idle) || (w_fifo_count == c_depth);
  assign w_start_edge = (r_state == c_st_idle) && bus.in_en && !r_prev_en;
  assign w_accept     = w_start_edge && !w_busy;

  assign w_push      = ((r_state == c_st_wait) && bus.core_done) || (r_state == c_st_push);
  assign w_push_data = (r_state == c_st_push) ? r_a : bus.core_result;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= c_st_idle;
      r_prev_en   <= 1'b0;
      r_in_cnt    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= OP_MUL;
      r_frame_err <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_prev_en <= bus.in_en;
      if (w_start_edge && w_busy) begin
        r_drop_err <= 1'b1;
      end
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_op            <= op_e'(bus.op_sel);
            r_a[IN_W-1:0]   <= bus.in_a;
            r_b[IN_W-1:0]   <= bus.in_b;
            if (c_n_in == 1) begin
              r_state <= (bus.op_sel == OP_PASS) ? c_st_push : c_st_issue;
            end else begin
              r_in_cnt <= c_cnt_w'(1);
              r_state  <= c_st_load;
            end
          end
        end
        c_st_load: begin
          if (!bus.in_en) begin
            r_frame_err <= 1'b1;
            r_in_cnt    <= '0;
            r_state     <= c_st_idle;
          end else begin
            r_a[r_in_cnt*IN_W +: IN_W] <= bus.in_a;
            r_b[r_in_cnt*IN_W +: IN_W] <= bus.in_b;
            if (r_in_cnt == c_last_in) begin
              r_in_cnt <= '0;
              r_state  <= (r_op == OP_PASS) ? c_st_push : c_st_issue;
            end else begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
          end
        end
        c_st_issue: r_state <= c_st_wait;
        c_st_wait: begin
          if (bus.core_done) begin
            r_state <= c_st_idle;
          end
        end
        c_st_push: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.core_a     = r_a;
  assign bus.core_b     = (r_op == OP_SUB) ? {~r_b[DATA_W-1], r_b[DATA_W-2:0]} : r_b;
  assign bus.core_op    = op_uses_add(r_op);
  assign bus.core_start = (r_state == c_st_issue);
  assign bus.busy       = w_busy;
  assign bus.frame_err  = r_frame_err;
  assign bus.drop_err   = r_drop_err;

  fpu_result_serializer #(
    .DATA_W     (DATA_W),
    .OUT_W      (OUT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_serializer (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .o_count     (w_fifo_count),
    .o_out_data  (bus.out_data),
    .o_out_valid (bus.out_valid),
    .i_out_ready (bus.out_ready),
    .o_out_last  (bus.out_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_fpu_serial_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_serial_frontend
// Summary  : Self-checking bench with a frame-level reference model and core stub.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fpu_serial_frontend;
  import fpu_serial_pkg::*;

  localparam int DATA_W     = 16;
  localparam int IN_W       = 4;
  localparam int OUT_W      = 8;
  localparam int FIFO_DEPTH = 2;
  localparam int N_IN       = DATA_W / IN_W;
  localparam int N_OUT      = DATA_W / OUT_W;

  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   ready_mode = 0;
  logic [OUT_W:0] exp_q [$];
  logic [OUT_W:0] obs_q [$];

  fpu_serial_frontend_if #(.DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  fpu_serial_frontend #(
    .DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Consumer: ready policy selected by ready_mode (0 low, 1 high, 2 random).
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        1:       bus.out_ready = 1'b1;
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (bus.out_valid && bus.out_ready) obs_q.push_back({bus.out_last, bus.out_data});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected output chunks of one result: LSB chunk first, last flag on the final one.
  task automatic model_result(input logic [1:0] op, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] res);
    logic [DATA_W-1:0] v;
    v = (op == 2'b11) ? a : res;
    for (int i = 0; i < N_OUT; i++) exp_q.push_back({(i == N_OUT - 1), v[i*OUT_W +: OUT_W]});
  endtask

  task automatic send_frame(input logic [1:0] op, input logic [DATA_W-1:0] a,
                            input logic [DATA_W-1:0] b, input int n_chunks);
    for (int i = 0; i < n_chunks; i++) begin
      bus.in_en  = 1'b1;
      bus.op_sel = op;
      bus.in_a   = a[i*IN_W +: IN_W];
      bus.in_b   = b[i*IN_W +: IN_W];
      tick();
    end
    bus.in_en = 1'b0;
  endtask

  // Core stub: called right after the last-chunk edge; answers lat cycles after the earliest edge.
  task automatic run_core(input logic [1:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] res,
                          input int lat);
    logic [DATA_W-1:0] eb;
    eb = b;
    if (op == 2'b10) eb[DATA_W-1] = ~eb[DATA_W-1];
    n_vec++;
    if (bus.core_start !== 1'b1) begin n_err++; $display("FAIL core_start_rise got %b want 1", bus.core_start); end
    n_vec++;
    if (bus.core_a !== a) begin n_err++; $display("FAIL core_a got %h want %h", bus.core_a, a); end
    n_vec++;
    if (bus.core_b !== eb) begin n_err++; $display("FAIL core_b got %h want %h", bus.core_b, eb); end
    n_vec++;
    if (bus.core_op !== (op != 2'b00)) begin n_err++; $display("FAIL core_op got %b want %b", bus.core_op, (op != 2'b00)); end
    tick();
    n_vec++;
    if (bus.core_start !== 1'b0) begin n_err++; $display("FAIL core_start_width got %b want 0", bus.core_start); end
    repeat (lat) tick();
    bus.core_done   = 1'b1;
    bus.core_result = res;
    n_vec++;
    if (bus.core_b !== eb) begin n_err++; $display("FAIL core_b_hold got %h want %h", bus.core_b, eb); end
    tick();
    bus.core_done = 1'b0;
    model_result(op, a, res);
  endtask

  task automatic run_pass(input logic [DATA_W-1:0] a);
    n_vec++;
    if (bus.core_start !== 1'b0) begin n_err++; $display("FAIL pass_no_start got %b want 0", bus.core_start); end
    tick();
    model_result(2'b11, a, '0);
  endtask

  task automatic wait_drain(input int bound);
    int cyc;
    cyc = 0;
    while (obs_q.size() < exp_q.size() && cyc < bound) begin tick(); cyc++; end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({bus.out_valid, bus.out_last, bus.out_data, bus.core_start, bus.core_op} !== '0) begin
      n_err++; $display("FAIL reset_out got %b%b%h%b%b want 0", bus.out_valid, bus.out_last, bus.out_data, bus.core_start, bus.core_op);
    end
    n_vec++;
    if ({bus.core_a, bus.core_b} !== '0) begin n_err++; $display("FAIL reset_core got %h %h want 0", bus.core_a, bus.core_b); end
    n_vec++;
    if ({bus.busy, bus.frame_err, bus.drop_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags got %b%b%b want 000", bus.busy, bus.frame_err, bus.drop_err);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    exp_q.delete(); obs_q.delete(); ready_mode = 1;
    send_frame(2'b01, 16'h5051, 16'h5051, N_IN);
    run_core(2'b01, 16'h5051, 16'h5051, 16'h5451, 0);
    wait_drain(200);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL add_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL add_chunk%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_mul_sub();
    exp_q.delete(); obs_q.delete(); ready_mode = 1;
    send_frame(2'b00, 16'h5007, 16'h5007, N_IN);
    run_core(2'b00, 16'h5007, 16'h5007, 16'h640E, 1);
    send_frame(2'b10, 16'h4D86, 16'h491C, N_IN);
    n_vec++;
    if (bus.core_b !== 16'hC91C) begin n_err++; $display("FAIL sub_core_b got %h want c91c", bus.core_b); end
    run_core(2'b10, 16'h4D86, 16'h491C, 16'h49F0, 2);
    wait_drain(200);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mulsub_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL mulsub_chunk%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pass_backpressure();
    exp_q.delete(); obs_q.delete(); ready_mode = 0;
    tick();
    send_frame(2'b11, 16'h1234, DATA_W'($urandom), N_IN);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pass_valid_early got %b want 0", bus.out_valid); end
    run_pass(16'h1234);
    n_vec++;
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid_rise got %b want 1", bus.out_valid); end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (bus.out_data !== 8'h34) begin n_err++; $display("FAIL bp_hold%0d got %h want 34", c, bus.out_data); end
    end
    ready_mode = 1;
    wait_drain(200);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL pass_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pass_chunk%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pass_popped got %b want 0", bus.out_valid); end
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] a, b, r;
    exp_q.delete(); obs_q.delete(); ready_mode = 1;
    send_frame(2'b01, 16'h1111, 16'h2222, 2);
    n_vec++;
    if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL abort_early got %b want 0", bus.frame_err); end
    tick();
    n_vec++;
    if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL abort_flag got %b want 1", bus.frame_err); end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({bus.core_start, bus.busy, bus.out_valid} !== 3'b000) begin
        n_err++; $display("FAIL abort_idle%0d got %b%b%b want 000", c, bus.core_start, bus.busy, bus.out_valid);
      end
      tick();
    end
    a = DATA_W'($urandom); b = DATA_W'($urandom); r = DATA_W'($urandom);
    send_frame(2'b01, a, b, N_IN);
    run_core(2'b01, a, b, r, 1);
    wait_drain(200);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL abort_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL abort_chunk%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_full_drop();
    exp_q.delete(); obs_q.delete(); ready_mode = 0;
    tick();
    send_frame(2'b11, 16'h0001, 16'h0000, N_IN);
    run_pass(16'h0001);
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL one_entry_busy got %b want 0", bus.busy); end
    send_frame(2'b11, 16'h0002, 16'h0000, N_IN);
    run_pass(16'h0002);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL full_busy got %b want 1", bus.busy); end
    n_vec++;
    if (bus.drop_err !== 1'b0) begin n_err++; $display("FAIL drop_early got %b want 0", bus.drop_err); end
    send_frame(2'b11, 16'h0003, 16'h0000, N_IN);
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if ({bus.drop_err, bus.busy, bus.core_start, bus.out_data} !== {3'b110, 8'h01}) begin
        n_err++; $display("FAIL drop_state%0d got %b%b%b %h want 110 01", c, bus.drop_err, bus.busy, bus.core_start, bus.out_data);
      end
      tick();
    end
    ready_mode = 1;
    wait_drain(200);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL full_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_chunk%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [1:0]        op;
    logic [DATA_W-1:0] a, b, r;
    int                cyc;
    exp_q.delete(); obs_q.delete(); ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      op = 2'($urandom_range(0, 3));
      a = DATA_W'($urandom); b = DATA_W'($urandom); r = DATA_W'($urandom);
      cyc = 0;
      while (bus.busy && cyc < 200) begin tick(); cyc++; end
      n_vec++;
      if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rand_busy_timeout frame %0d got %b want 0", f, bus.busy); end
      send_frame(op, a, b, N_IN);
      if (op == 2'b11) run_pass(a);
      else run_core(op, a, b, r, $urandom_range(0, 3));
    end
    wait_drain(1000);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_chunk%0d got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_q.delete(); obs_q.delete(); ready_mode = 0;
    tick();
    send_frame(2'b11, 16'hBEEF, 16'h0000, N_IN);
    run_pass(16'hBEEF);
    send_frame(2'b01, 16'h3C00, 16'h3C00, N_IN);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    bus.core_done   = 1'b1;
    bus.core_result = 16'h4000;
    tick();
    bus.core_done = 1'b0;
    repeat (2) tick();
    n_vec++;
    if ({bus.out_valid, bus.out_last, bus.out_data, bus.core_start, bus.core_op} !== '0) begin
      n_err++; $display("FAIL rst_wait_out got %b%b%h%b%b want 0", bus.out_valid, bus.out_last, bus.out_data, bus.core_start, bus.core_op);
    end
    n_vec++;
    if ({bus.core_a, bus.core_b} !== '0) begin n_err++; $display("FAIL rst_wait_core got %h %h want 0", bus.core_a, bus.core_b); end
    n_vec++;
    if ({bus.busy, bus.frame_err, bus.drop_err} !== 3'b000) begin
      n_err++; $display("FAIL rst_wait_flags got %b%b%b want 000", bus.busy, bus.frame_err, bus.drop_err);
    end
    ready_mode = 1;
    repeat (5) tick();
    n_vec++;
    if (obs_q.size() != 0) begin n_err++; $display("FAIL rst_wait_stream got %0d chunks want 0", obs_q.size()); end
  endtask

  initial begin
    reset           = 1'b0;
    bus.in_en       = 1'b0;
    bus.op_sel      = 2'b00;
    bus.in_a        = '0;
    bus.in_b        = '0;
    bus.core_done   = 1'b0;
    bus.core_result = '0;
    test_reset();
    test_add();
    test_mul_sub();
    test_pass_backpressure();
    test_abort();
    test_full_drop();
    test_random();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
